// File: rtl/pulse_interval_meter.sv
// Start/stop pulse interval meter: counts clk cycles between rising edges on
// start and stop, and presents the count under a valid/ready handshake.
module pulse_interval_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned MISS_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  output logic [CNT_W-1:0]  result,
  output logic              result_timeout,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic [MISS_W-1:0] missed
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (&v) ? v : v + MISS_W'(1);
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    result_q, result_d;
  logic                timeout_q, timeout_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [MISS_W-1:0]   missed_q, missed_d;
  logic                start_prev_q, stop_prev_q;
  logic                start_rise, stop_rise;

  assign start_rise = start & ~start_prev_q;
  assign stop_rise  = stop  & ~stop_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    missed_d  = missed_q;

    unique case (state_q)
      IDLE: begin
        if (en && start_rise && stop_rise) begin
          result_d  = '0;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end else if (en && start_rise) begin
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        if (!en) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (stop_rise) begin
          // Stop is checked before timeout so a coincident stop reports a real interval.
          result_d  = cnt_q;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = HOLD;
        end else if (cnt_q == TIMEOUT_C) begin
          result_d  = TIMEOUT_C;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (result_ready) begin
          if (en && start_rise && stop_rise) begin
            result_d  = '0;
            timeout_d = 1'b0;
          end else if (en && start_rise) begin
            cnt_d   = CNT_W'(1);
            valid_d = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (start_rise) begin
          missed_d = sat_inc(missed_q);
        end
      end

      default: begin
        cnt_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      result_q     <= '0;
      timeout_q    <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      missed_q     <= '0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      missed_q     <= missed_d;
      start_prev_q <= start;
      stop_prev_q  <= stop;
    end
  end

  assign result         = result_q;
  assign result_timeout = timeout_q;
  assign result_valid   = valid_q;
  assign busy           = busy_q;
  assign missed         = missed_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Directed bench for pulse_interval_meter with a short timeout so the
// timeout paths are reachable in a few dozen cycles.
module tb_pulse_interval_meter;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned MISS_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  result;
  logic              result_timeout;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic [MISS_W-1:0] missed;

  int n_checks = 0;
  int n_fails  = 0;

  pulse_interval_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .MISS_W  (MISS_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .en             (en),
    .start          (start),
    .stop           (stop),
    .result         (result),
    .result_timeout (result_timeout),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy),
    .missed         (missed)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    en           = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    result_ready = 1'b1;
    #1;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_timeout", 64'(result_timeout), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_missed", 64'(missed), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Interval of 5 cycles, ready high.
    start = 1'b1; step(); start = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    repeat (4) step();
    chk("t1_valid_pre", 64'(result_valid), 64'd0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t1_valid", 64'(result_valid), 64'd1);
    chk("t1_result", 64'(result), 64'd5);
    chk("t1_timeout", 64'(result_timeout), 64'd0);
    chk("t1_busy_hold", 64'(busy), 64'd0);
    step();
    chk("t1_valid_drop", 64'(result_valid), 64'd0);

    // Start and stop together.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("t2_valid", 64'(result_valid), 64'd1);
    chk("t2_result", 64'(result), 64'd0);
    chk("t2_busy", 64'(busy), 64'd0);
    step();
    chk("t2_valid_drop", 64'(result_valid), 64'd0);

    // Timeout with no stop.
    start = 1'b1; step(); start = 1'b0;
    repeat (19) step();
    chk("t3_busy_run", 64'(busy), 64'd1);
    chk("t3_valid_pre", 64'(result_valid), 64'd0);
    step();
    chk("t3_valid", 64'(result_valid), 64'd1);
    chk("t3_result", 64'(result), 64'd20);
    chk("t3_timeout", 64'(result_timeout), 64'd1);
    chk("t3_busy_hold", 64'(busy), 64'd0);
    step();
    chk("t3_valid_drop", 64'(result_valid), 64'd0);

    // Stop coincides with cnt == TIMEOUT: stop wins.
    start = 1'b1; step(); start = 1'b0;
    repeat (19) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3b_valid", 64'(result_valid), 64'd1);
    chk("t3b_result", 64'(result), 64'd20);
    chk("t3b_timeout", 64'(result_timeout), 64'd0);
    step();

    // Backpressure: missed starts while holding, then back-to-back accept.
    result_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (2) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_result", 64'(result), 64'd3);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; step(); start = 1'b0; step();
    end
    chk("t4_missed", 64'(missed), 64'd3);
    chk("t4_result_hold", 64'(result), 64'd3);
    chk("t4_valid_hold", 64'(result_valid), 64'd1);
    result_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("t4_b2b_valid", 64'(result_valid), 64'd0);
    chk("t4_b2b_busy", 64'(busy), 64'd1);
    repeat (6) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_result2", 64'(result), 64'd7);
    chk("t4_valid2", 64'(result_valid), 64'd1);
    chk("t4_missed_kept", 64'(missed), 64'd3);
    step();
    chk("t4_valid_drop", 64'(result_valid), 64'd0);

    // Enable dropped mid-run aborts without a result.
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    en = 1'b0; step();
    chk("t5_busy_abort", 64'(busy), 64'd0);
    chk("t5_valid_abort", 64'(result_valid), 64'd0);
    en = 1'b1; step();
    chk("t5_valid_after", 64'(result_valid), 64'd0);

    // Reset mid-run, then a clean 9-cycle measurement.
    start = 1'b1; step(); start = 1'b0;
    step();
    reset_n = 1'b0; #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_result", 64'(result), 64'd0);
    chk("t5_rst_missed", 64'(missed), 64'd0);
    chk("t5_rst_valid", 64'(result_valid), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("t5_idle_busy", 64'(busy), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t5_result9", 64'(result), 64'd9);
    chk("t5_valid9", 64'(result_valid), 64'd1);
    step();

    // Stray stop ignored; held start counts once.
    stop = 1'b1; step(); stop = 1'b0; step();
    chk("t6_stray_valid", 64'(result_valid), 64'd0);
    chk("t6_stray_busy", 64'(busy), 64'd0);
    start = 1'b1; step();
    chk("t6_busy", 64'(busy), 64'd1);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t6_result", 64'(result), 64'd2);
    chk("t6_valid", 64'(result_valid), 64'd1);
    repeat (3) step();
    start = 1'b0;
    chk("t6_no_retrig_busy", 64'(busy), 64'd0);
    chk("t6_no_retrig_valid", 64'(result_valid), 64'd0);
    chk("t6_missed", 64'(missed), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pulse_interval_meter.md
Name: pulse_interval_meter

Overview:
- Receive side of the start/stop pulse pair used for TDC testing.
- Detects rising edges on a start input and a stop input, then counts the clk cycles between them.
- Presents the interval as a result word under a valid/ready handshake.
- Sits downstream of the two-pulse generator and serves as the coarse cycle-count reference that fine TDC measurements are checked against.

Parameters:
- CNT_W, 32, width of interval counter and result.
- TIMEOUT, 1000, max cycles to wait for stop after start before aborting with timeout flag; must be >= 1 and < 2^CNT_W.
- MISS_W, 8, width of saturating missed-start counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable; low aborts a measurement in progress.
- start  input  1  start pulse, synchronous to clk; rising edge is significant.
- stop  input  1  stop pulse, synchronous to clk; rising edge is significant.
- result  output  CNT_W  measured interval in clk cycles.
- result_timeout  output  1  result was produced by timeout, not by stop.
- result_valid  output  1  result/result_timeout are valid.
- result_ready  input  1  consumer accepts the result.
- busy  output  1  high in RUN state.
- missed  output  MISS_W  count of start edges dropped while a result is pending; saturating.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE, cnt=0, result=0, result_timeout=0, result_valid=0, busy=0, missed=0.
  - Edge-detect history registers start_d and stop_d cleared to 0.
- Edge detect:
  - start_rise = start & ~start_d; stop_rise = stop & ~stop_d.
  - start_d/stop_d register every cycle regardless of state.
  - A pulse held high for several cycles counts once.
- State IDLE:
  - If en & start_rise & stop_rise: result<=0, result_timeout<=0 → HOLD.
  - Else if en & start_rise: cnt<=1 → RUN.
  - stop_rise alone is ignored.
- State RUN (busy=1):
  - en low: → IDLE, no result, cnt<=0.
  - Else if stop_rise: result<=cnt, result_timeout<=0 → HOLD.
  - Else if cnt==TIMEOUT: result<=TIMEOUT, result_timeout<=1 → HOLD.
  - Else cnt<=cnt+1.
  - start_rise in RUN is ignored; no re-trigger, not counted as missed.
  - stop_rise in the same cycle as cnt==TIMEOUT: stop wins, result_timeout=0.
- Interval definition: start_rise sampled at cycle k, stop_rise sampled at cycle k+N gives result N, for 0 <= N <= TIMEOUT.
- Latency: result_valid rises on the clock edge that samples stop_rise, i.e. visible in cycle k+N+1.
- State HOLD:
  - result_valid=1; result and result_timeout held stable until transfer.
  - en has no effect in HOLD.
  - Transfer occurs when result_valid & result_ready; result_valid drops on the next edge.
  - On transfer with en & start_rise in the same cycle: enter RUN with cnt<=1 (back-to-back accepted, not missed). start_rise & stop_rise together in that cycle: result<=0, stay in HOLD with result_valid=1.
  - On transfer otherwise: → IDLE.
  - start_rise without transfer: missed<=missed+1, saturating at all-ones.
- Counter width: cnt never exceeds TIMEOUT, so no wrap-around.
- Reset mid-operation: any state goes to IDLE immediately; a pending result is discarded.
- missed is cleared only by reset.

Test Plan:
- Start at cycle 10, stop at cycle 15, ready=1 → result=5, result_timeout=0, result_valid high exactly one cycle, in cycle 16.
- Start and stop in same cycle → result=0, result_valid next cycle.
- TIMEOUT=20, start with no stop → result=20, result_timeout=1, 21 cycles after start; busy high throughout RUN. Repeat with stop at the cycle where cnt==TIMEOUT → result=20, result_timeout=0.
- ready=0 after result; 3 further start pulses → result stable, missed=3. Raise ready together with a 4th start, then stop 7 cycles later → first result accepted, new result=7, missed stays 3.
- Start, then deassert en 4 cycles later → busy drops, no result_valid. Start, then reset_n low for 1 cycle mid-RUN → all outputs 0 and state IDLE, then a clean 9-cycle measurement → result=9.
- Stop before any start, and start held high 6 cycles then stop 2 cycles after start edge → stray stop ignored; result=2, not re-triggered by held start.
